// File: rtl/nn_pkg.sv
// nn_pkg: shared constants, types and helpers for the neural-network
// datapath blocks.
//   NN_WIDTH        default score width
//   NN_OUTPUT_SIZE  default number of output classes
//   argmax_state_t  nn_argmax controller states
//   nn_idx_w()      class-index width, never below one bit
package nn_pkg;

  localparam int NN_WIDTH       = 16;
  localparam int NN_OUTPUT_SIZE = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

  // A single class still needs a one-bit index field.
  function automatic int nn_idx_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/nn_max_sel.sv
// nn_max_sel: combinational compare-select for the serial argmax scan.
// Ports:
//   candidate / cand_idx  score under test and its class index
//   cur_max   / cur_idx   running maximum and its class index
//   new_max   / new_idx   updated running maximum and index
// The test is strict greater-than, so an equal candidate never replaces
// the running maximum and the lowest index wins a tie.
module nn_max_sel
  import nn_pkg::*;
#(
  parameter int WIDTH = NN_WIDTH,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] candidate,
  input  logic [IDX_W-1:0] cand_idx,
  input  logic [WIDTH-1:0] cur_max,
  input  logic [IDX_W-1:0] cur_idx,
  output logic [WIDTH-1:0] new_max,
  output logic [IDX_W-1:0] new_idx
);

  // Keep the current winner unless the candidate is strictly larger.
  always_comb begin
    new_max = cur_max;
    new_idx = cur_idx;
    if (candidate > cur_max) begin
      new_max = candidate;
      new_idx = cand_idx;
    end else begin
      new_max = cur_max;
      new_idx = cur_idx;
    end
  end

endmodule

// File: rtl/nn_argmax.sv
// nn_argmax: output-classification stage. Captures one vector of
// OUTPUT_SIZE unsigned scores on a valid/ready handshake, scans it one
// score per cycle through a single comparator, and presents the winning
// class index and score on a held valid/ready output.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   input vector handshake
//   scores_flat          score i at [i*WIDTH +: WIDTH]
//   mask_flat            arithmetic masks (only with NN_ARGMAX_UNMASK_EN)
//   out_valid, out_ready result handshake
//   class_idx, max_score result; stable while out_valid is high
//   busy                 high while scanning or holding a result
// Build option: define NN_ARGMAX_UNMASK_EN to add mask_flat and store
// score - mask (mod 2^WIDTH) at capture, recombining arithmetic shares.
module nn_argmax
  import nn_pkg::*;
#(
  parameter int OUTPUT_SIZE = NN_OUTPUT_SIZE,
  parameter int WIDTH       = NN_WIDTH,
  parameter int IDX_W       = nn_idx_w(OUTPUT_SIZE)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [OUTPUT_SIZE*WIDTH-1:0] scores_flat,
`ifdef NN_ARGMAX_UNMASK_EN
  input  logic [OUTPUT_SIZE*WIDTH-1:0] mask_flat,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_W-1:0]             class_idx,
  output logic [WIDTH-1:0]             max_score,
  output logic                         busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_SIZE - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  argmax_state_t    state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [WIDTH-1:0] buf_r [OUTPUT_SIZE];
  logic [WIDTH-1:0] max_r;
  logic [IDX_W-1:0] idx_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  logic [WIDTH-1:0] cap_s [OUTPUT_SIZE];
  logic             capture_s;
  logic [WIDTH-1:0] new_max_s;
  logic [IDX_W-1:0] new_idx_s;

  // Values written into the buffer at capture (unmasked when enabled).
  always_comb begin
    for (int i = 0; i < OUTPUT_SIZE; i++) begin
`ifdef NN_ARGMAX_UNMASK_EN
      cap_s[i] = scores_flat[i*WIDTH +: WIDTH] - mask_flat[i*WIDTH +: WIDTH];
`else
      cap_s[i] = scores_flat[i*WIDTH +: WIDTH];
`endif
    end
  end

  // in_ready is only ever high in IDLE, so the state test is the handshake.
  always_comb begin
    if (!rst && (state_r == IDLE) && in_valid) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
  end

  nn_max_sel #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_max_sel (
    .candidate (buf_r[ptr_r]),
    .cand_idx  (ptr_r),
    .cur_max   (max_r),
    .cur_idx   (idx_r),
    .new_max   (new_max_s),
    .new_idx   (new_idx_s)
  );

  // Score buffer: loaded once per vector, contents are don't-care otherwise.
  always_ff @(posedge clk) begin
    if (capture_s) begin
      for (int i = 0; i < OUTPUT_SIZE; i++) begin
        buf_r[i] <= cap_s[i];
      end
    end
  end

  // Controller: state, scan pointer, running result and registered flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      ptr_r       <= {IDX_W{1'b0}};
      max_r       <= {WIDTH{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (capture_s) begin
            // Score 0 seeds the running max; the scan starts at index 1.
            max_r      <= cap_s[0];
            idx_r      <= {IDX_W{1'b0}};
            ptr_r      <= ONE_IDX;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            if (OUTPUT_SIZE == 1) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
            end else begin
              state_r     <= SCAN;
              out_valid_r <= 1'b0;
            end
          end else begin
            state_r    <= IDLE;
            in_ready_r <= 1'b1;
          end
        end
        SCAN: begin
          max_r <= new_max_s;
          idx_r <= new_idx_s;
          ptr_r <= ptr_r + ONE_IDX;
          if (ptr_r == LAST_IDX) begin
            state_r     <= DONE;
            out_valid_r <= 1'b1;
          end else begin
            state_r <= SCAN;
          end
        end
        DONE: begin
          // Result registers are untouched here, so they hold until consumed.
          if (out_ready) begin
            state_r     <= IDLE;
            ptr_r       <= {IDX_W{1'b0}};
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          ptr_r       <= {IDX_W{1'b0}};
          max_r       <= {WIDTH{1'b0}};
          idx_r       <= {IDX_W{1'b0}};
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign class_idx = idx_r;
  assign max_score = max_r;

endmodule

// File: tb/tb_nn_argmax.sv
// tb_nn_argmax: directed and randomized checks of nn_argmax (N=5, WIDTH=16)
// against a reference argmax computed in the bench.
module tb_nn_argmax;

  localparam int N  = 5;
  localparam int W  = 16;
  localparam int IW = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [N*W-1:0] scores_flat;
`ifdef NN_ARGMAX_UNMASK_EN
  logic [N*W-1:0] mask_flat;
`endif
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] class_idx;
  logic [W-1:0]  max_score;
  logic          busy;

  int errors;
  int checks;

  logic [W-1:0] vec [N];
  logic [W-1:0] msk [N];

  nn_argmax #(
    .OUTPUT_SIZE (N),
    .WIDTH       (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .scores_flat (scores_flat),
`ifdef NN_ARGMAX_UNMASK_EN
    .mask_flat   (mask_flat),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .class_idx   (class_idx),
    .max_score   (max_score),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: recombine shares, take the largest value, then the first
  // position holding it.
  task automatic model(output logic [31:0] exp_idx, output logic [31:0] exp_max);
    int u [N];
    int mx;
    mx = 0;
    for (int i = 0; i < N; i++) begin
      u[i] = (int'(vec[i]) - int'(msk[i]) + 65536) % 65536;
      if (u[i] > mx) mx = u[i];
    end
    exp_max = mx;
    exp_idx = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (u[i] == mx) exp_idx = i;
    end
  endtask

  task automatic set_vec(input int a, input int b, input int c, input int d, input int e);
    vec[0] = 16'(a); vec[1] = 16'(b); vec[2] = 16'(c); vec[3] = 16'(d); vec[4] = 16'(e);
    for (int i = 0; i < N; i++) msk[i] = 16'h0000;
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      scores_flat[i*W +: W] = vec[i];
`ifdef NN_ARGMAX_UNMASK_EN
      mask_flat[i*W +: W] = msk[i];
`endif
    end
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < N; i++) begin
      scores_flat[i*W +: W] = 16'($urandom);
`ifdef NN_ARGMAX_UNMASK_EN
      mask_flat[i*W +: W] = 16'($urandom);
`endif
    end
  endtask

  task automatic handshake_in(input string tag);
    int cyc;
    cyc = 0;
    while (in_ready !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, ":in_ready_before"}, 32'(in_ready), 32'd1);
    drive_inputs();
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  task automatic run_vec(input string tag, input int stall);
    logic [31:0] exp_idx;
    logic [31:0] exp_max;
    int cyc;
    model(exp_idx, exp_max);
    handshake_in(tag);
    check({tag, ":busy_scan"}, 32'(busy), 32'd1);
    check({tag, ":in_ready_scan"}, 32'(in_ready), 32'd0);
    cyc = 1;
    while (out_valid !== 1'b1 && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check({tag, ":latency"}, 32'(cyc), 32'd5);
    check({tag, ":class_idx"}, 32'(class_idx), exp_idx);
    check({tag, ":max_score"}, 32'(max_score), exp_max);
    // Offer another vector while the result waits; it must be refused.
    in_valid = 1'b1;
    drive_inputs();
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
      check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
      check({tag, ":hold_in_ready"}, 32'(in_ready), 32'd0);
      check({tag, ":hold_idx"}, 32'(class_idx), exp_idx);
      check({tag, ":hold_max"}, 32'(max_score), exp_max);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ":post_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ":post_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ":post_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int mode;
    int v;
    errors      = 0;
    checks      = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    scores_flat = '0;
`ifdef NN_ARGMAX_UNMASK_EN
    mask_flat   = '0;
`endif
    for (int i = 0; i < N; i++) msk[i] = 16'h0000;

    repeat (3) @(posedge clk);
    #1;
    check("rst:in_ready", 32'(in_ready), 32'd1);
    check("rst:out_valid", 32'(out_valid), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:class_idx", 32'(class_idx), 32'd0);
    check("rst:max_score", 32'(max_score), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    set_vec(21175, 21175, 21175, 21175, 21175);
    run_vec("all_equal", 0);
    set_vec(10, 200, 7, 200, 3);
    run_vec("tie", 1);
    set_vec(1, 2, 3, 4, 16'hFFFF);
    run_vec("last_max", 0);
    set_vec(300, 5, 299, 6, 7);
    run_vec("stall10", 10);

    // Reset on the second SCAN cycle aborts the vector.
    set_vec(100, 200, 300, 400, 500);
    handshake_in("abort");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort:in_ready", 32'(in_ready), 32'd1);
    check("abort:out_valid", 32'(out_valid), 32'd0);
    check("abort:busy", 32'(busy), 32'd0);
    check("abort:class_idx", 32'(class_idx), 32'd0);
    check("abort:max_score", 32'(max_score), 32'd0);
    set_vec(5, 9, 1, 0, 0);
    run_vec("after_abort", 0);

`ifdef NN_ARGMAX_UNMASK_EN
    set_vec(16'h0010, 16'h1234, 16'h0000, 16'h0005, 16'h0100);
    msk[0] = 16'h0008; msk[1] = 16'h1230; msk[2] = 16'hFFF0;
    msk[3] = 16'h0000; msk[4] = 16'h00F0;
    run_vec("unmask", 0);
`endif

    for (int t = 0; t < 25; t++) begin
      mode = $urandom_range(0, 2);
      v    = $urandom_range(0, 65535);
      for (int i = 0; i < N; i++) begin
        case (mode)
          0: vec[i] = 16'($urandom);
          1: vec[i] = 16'($urandom_range(0, 3));
          default: vec[i] = 16'(v);
        endcase
`ifdef NN_ARGMAX_UNMASK_EN
        msk[i] = 16'($urandom);
`else
        msk[i] = 16'h0000;
`endif
      end
      run_vec($sformatf("rand%0d", t), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
